// File: rtl/logic8_serial_if.sv
// Start/busy/done handshake and operand/result bus between the ALU controller
// and the bit-serial logic unit.
interface logic8_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Cout;
  logic             zero;

  modport master (
    output start, op, A, B,
    input  busy, done, Cout, zero
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, Cout, zero
  );
endinterface

// File: rtl/logic8_serial.sv
// Bit-serial NOR/AND/OR/XOR unit: one result bit per clock, LSB first, with a
// registered result, zero flag and one-cycle done pulse.
module logic8_serial #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  logic8_serial_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [1:0]       op_q, op_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] cout_q, cout_d;
  logic             zero_q, zero_d;

  logic             bit_val;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    bit_val = 1'b0;
    unique case (op_q)
      2'b00: bit_val = ~(sa_q[0] | sb_q[0]);
      2'b01: bit_val = sa_q[0] & sb_q[0];
      2'b10: bit_val = sa_q[0] | sb_q[0];
      2'b11: bit_val = sa_q[0] ^ sb_q[0];
      default: bit_val = 1'b0;
    endcase
  end

  assign shifted = {bit_val, sr_q[WIDTH-1:1]};

  // DONE accepts a new start just like IDLE so back-to-back operations lose no cycle.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    op_d    = op_q;
    count_d = count_q;
    cout_d  = cout_q;
    zero_d  = zero_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          sa_d    = bus.A;
          sb_d    = bus.B;
          op_d    = bus.op;
          sr_d    = '0;
          count_d = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sr_d    = shifted;
        sa_d    = {1'b0, sa_q[WIDTH-1:1]};
        sb_d    = {1'b0, sb_q[WIDTH-1:1]};
        count_d = count_q + 1'b1;
        if (count_q == LAST_COUNT) begin
          cout_d  = shifted;
          zero_d  = (shifted == '0);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      op_q    <= '0;
      count_q <= '0;
      cout_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      op_q    <= op_d;
      count_q <= count_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
    end
  end

  // Status outputs decode straight from the state register, so nothing from the inputs reaches them.
  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.Cout = cout_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_logic8_serial.sv
// Directed-vector bench for logic8_serial: function table, latency, handshake,
// mid-run start rejection, back-to-back starts and reset behaviour.
module tb_logic8_serial;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  logic8_serial_if #(.WIDTH(8)) bus ();

  logic8_serial #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    bus.start = s;
    bus.op    = o;
    bus.A     = a;
    bus.B     = b;
  endtask

  // Counts cycles after the accepting edge until done, with a bound.
  task automatic waitDone(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && lat < 30) begin
      if (bus.busy === 1'b1) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  task automatic runOp(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_c, input logic exp_z, input string tag);
    int lat;
    int busy_cnt;
    applyStimulus(1'b1, o, a, b);
    tick();
    applyStimulus(1'b0, ~o, ~a, ~b);
    waitDone(lat, busy_cnt);
    checkOutput({tag, "_latency"}, lat, 8);
    checkOutput({tag, "_busy_cycles"}, busy_cnt, 8);
    checkOutput({tag, "_busy_at_done"}, {31'd0, bus.busy}, 0);
    checkOutput({tag, "_cout"}, {24'd0, bus.Cout}, {24'd0, exp_c});
    checkOutput({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, exp_z});
    tick();
    checkOutput({tag, "_done_one_cycle"}, {31'd0, bus.done}, 0);
  endtask

  initial begin
    int lat;
    int busy_cnt;
    int extra_done;
    int extra_busy;

    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 2'b00, 8'h00, 8'h00);
    tick();
    tick();
    checkOutput("rst_busy", {31'd0, bus.busy}, 0);
    checkOutput("rst_done", {31'd0, bus.done}, 0);
    checkOutput("rst_cout", {24'd0, bus.Cout}, 0);
    checkOutput("rst_zero", {31'd0, bus.zero}, 0);
    rst_n = 1'b1;
    tick();

    runOp(2'b00, 8'h0F, 8'h33, 8'hC0, 1'b0, "nor_0f_33");
    runOp(2'b00, 8'hFF, 8'h00, 8'h00, 1'b1, "nor_ff_00");
    runOp(2'b01, 8'hF0, 8'h3C, 8'h30, 1'b0, "and_f0_3c");
    runOp(2'b10, 8'h81, 8'h18, 8'h99, 1'b0, "or_81_18");

    // XOR with a stray start pulse three cycles into the run.
    applyStimulus(1'b1, 2'b11, 8'hAA, 8'h55);
    tick();
    applyStimulus(1'b0, 2'b00, 8'h12, 8'h34);
    lat = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && lat < 30) begin
      if (lat == 3) applyStimulus(1'b1, 2'b01, 8'h00, 8'hFF);
      else          applyStimulus(1'b0, 2'b00, 8'h12, 8'h34);
      if (bus.busy === 1'b1) busy_cnt++;
      tick();
      lat++;
    end
    checkOutput("xor_dist_latency", lat, 8);
    checkOutput("xor_dist_busy_cycles", busy_cnt, 8);
    checkOutput("xor_dist_cout", {24'd0, bus.Cout}, 32'hFF);
    checkOutput("xor_dist_zero", {31'd0, bus.zero}, 0);
    extra_done = 0;
    extra_busy = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done === 1'b1) extra_done++;
      if (bus.busy === 1'b1) extra_busy++;
    end
    checkOutput("xor_dist_no_extra_done", extra_done, 0);
    checkOutput("xor_dist_no_extra_busy", extra_busy, 0);
    checkOutput("xor_dist_cout_hold", {24'd0, bus.Cout}, 32'hFF);

    // Back-to-back: start held high, operands switched on the first done cycle.
    applyStimulus(1'b1, 2'b01, 8'hFF, 8'h0F);
    tick();
    waitDone(lat, busy_cnt);
    checkOutput("b2b_first_latency", lat, 8);
    checkOutput("b2b_first_cout", {24'd0, bus.Cout}, 32'h0F);
    applyStimulus(1'b1, 2'b00, 8'h00, 8'h00);
    tick();
    applyStimulus(1'b0, 2'b00, 8'h00, 8'h00);
    checkOutput("b2b_second_busy", {31'd0, bus.busy}, 1);
    waitDone(lat, busy_cnt);
    checkOutput("b2b_done_spacing", lat + 1, 9);
    checkOutput("b2b_second_cout", {24'd0, bus.Cout}, 32'hFF);
    checkOutput("b2b_second_zero", {31'd0, bus.zero}, 0);
    tick();

    // Reset four cycles into a run aborts it.
    applyStimulus(1'b1, 2'b00, 8'h0F, 8'h33);
    tick();
    applyStimulus(1'b0, 2'b00, 8'h0F, 8'h33);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("midrst_busy", {31'd0, bus.busy}, 0);
    checkOutput("midrst_done", {31'd0, bus.done}, 0);
    checkOutput("midrst_cout", {24'd0, bus.Cout}, 0);
    checkOutput("midrst_zero", {31'd0, bus.zero}, 0);
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done === 1'b1) extra_done++;
    end
    checkOutput("midrst_no_done", extra_done, 0);
    runOp(2'b00, 8'h0F, 8'h33, 8'hC0, 1'b0, "post_rst_nor");
    tick();
    tick();
    checkOutput("idle_cout_hold", {24'd0, bus.Cout}, 32'hC0);

    // Reset and start on the same edge: reset wins.
    applyStimulus(1'b1, 2'b10, 8'hF0, 8'h0F);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b0, 2'b10, 8'hF0, 8'h0F);
    checkOutput("rst_start_busy", {31'd0, bus.busy}, 0);
    checkOutput("rst_start_cout", {24'd0, bus.Cout}, 0);
    tick();
    checkOutput("rst_start_busy_next", {31'd0, bus.busy}, 0);
    extra_done = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done === 1'b1) extra_done++;
    end
    checkOutput("rst_start_no_done", extra_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
